// File: rtl/mem_lsu_ctrl_if.sv
// Core-side request/response bundle of the load/store unit.
// The core drives the master modport; the LSU uses the slave modport.
interface mem_lsu_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [31:0]     req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_lsu_ctrl.sv
// RV32i load/store unit: core request port to word-addressed data memory with
// read-modify-write sub-word stores. Optional macro LSU_RANGE_CHECK_EN faults upper address bits.
module mem_lsu_ctrl #(
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned XLEN           = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  mem_lsu_ctrl_if.slave             core_if,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic                      mem_we_o,
  output logic                      mem_oe_o,
  inout  wire  [XLEN-1:0]           mem_data_io
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_ACK} state_e;

  state_e                    state_q;
  logic                      ready_q;
  logic                      we_q;
  logic [1:0]                size_q;
  logic                      uns_q;
  logic [1:0]                lane_q;
  logic [15:0]               sub_wdata_q;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q;
  logic                      mem_we_q;
  logic                      mem_oe_q;
  logic [XLEN-1:0]           mem_wdata_q;
  logic                      rsp_valid_q;
  logic [XLEN-1:0]           rsp_rdata_q;
  logic                      rsp_err_q;

  logic                      accept_c;
  logic                      misalign_c;
  logic                      range_fault_c;
  logic [MEM_ADDR_WIDTH-1:0] word_addr_c;

`ifdef LSU_RANGE_CHECK_EN
  assign range_fault_c = |core_if.req_addr[31:MEM_ADDR_WIDTH+2];
`else
  logic unused_upper_c;
  assign unused_upper_c = ^core_if.req_addr[31:MEM_ADDR_WIDTH+2];
  assign range_fault_c  = 1'b0;
`endif

  // Request decode, only meaningful on the accept edge
  always_comb begin
    accept_c    = 1'b0;
    misalign_c  = 1'b0;
    word_addr_c = core_if.req_addr[MEM_ADDR_WIDTH+1:2];
    accept_c    = core_if.req_valid & ready_q;
    if (core_if.req_size == SZ_HALF) begin
      misalign_c = core_if.req_addr[0];
    end else if (core_if.req_size[1]) begin
      misalign_c = |core_if.req_addr[1:0];
    end
  end

  function automatic logic [XLEN-1:0] merge_f(input logic [XLEN-1:0] old_w,
                                              input logic [15:0]     wd,
                                              input logic [1:0]      sz,
                                              input logic [1:0]      lane);
    logic [XLEN-1:0] r;
    r = old_w;
    if (sz == SZ_BYTE) r[{lane, 3'b000} +: 8] = wd[7:0];
    else               r[{lane[1], 4'b0000} +: 16] = wd;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] extract_f(input logic [XLEN-1:0] w,
                                                input logic [1:0]      sz,
                                                input logic            uns,
                                                input logic [1:0]      lane);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    if (sz == SZ_BYTE)      r = {{(XLEN-8){b[7] & ~uns}}, b};
    else if (sz == SZ_HALF) r = {{(XLEN-16){h[15] & ~uns}}, h};
    else                    r = w;
    return r;
  endfunction

  // Sequencer: every output is a register updated alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      lane_q      <= '0;
      sub_wdata_q <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (accept_c) begin
            ready_q     <= 1'b0;
            we_q        <= core_if.req_we;
            size_q      <= core_if.req_size;
            uns_q       <= core_if.req_unsigned;
            lane_q      <= core_if.req_addr[1:0];
            sub_wdata_q <= core_if.req_wdata[15:0];
            if (misalign_c || range_fault_c) begin
              state_q     <= S_ACK;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (core_if.req_we && core_if.req_size[1]) begin
              state_q     <= S_WR;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= word_addr_c;
              mem_wdata_q <= core_if.req_wdata;
            end else begin
              state_q    <= S_RD;
              mem_oe_q   <= 1'b1;
              mem_addr_q <= word_addr_c;
            end
          end
        end
        S_RD: begin
          mem_oe_q <= 1'b0;
          if (we_q) begin
            state_q     <= S_WR;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= merge_f(mem_data_io, sub_wdata_q, size_q, lane_q);
          end else begin
            state_q     <= S_ACK;
            mem_addr_q  <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= extract_f(mem_data_io, size_q, uns_q, lane_q);
          end
        end
        S_WR: begin
          state_q     <= S_ACK;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
        S_ACK: begin
          state_q     <= S_IDLE;
          ready_q     <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_if.req_ready = ready_q;
  assign core_if.rsp_valid = rsp_valid_q;
  assign core_if.rsp_rdata = rsp_rdata_q;
  assign core_if.rsp_err   = rsp_err_q;
  assign mem_addr_o        = mem_addr_q;
  assign mem_we_o          = mem_we_q;
  assign mem_oe_o          = mem_oe_q;
  // The memory owns the bus whenever no write is in progress
  assign mem_data_io       = mem_we_q ? mem_wdata_q : {XLEN{1'bz}};

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Self-checking bench for mem_lsu_ctrl: behavioural memory, reference memory
// model and a response scoreboard keyed on expected completion cycle.
module tb_mem_lsu_ctrl;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          mem_oe;
  wire  [31:0]   mem_data;

  mem_lsu_ctrl_if #(.XLEN(32)) bus ();

  mem_lsu_ctrl #(.MEM_ADDR_WIDTH(AW), .XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_if    (bus),
    .mem_addr_o (mem_addr),
    .mem_we_o   (mem_we),
    .mem_oe_o   (mem_oe),
    .mem_data_io(mem_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];

  assign mem_data = mem_oe ? mem[mem_addr] : 32'hzzzz_zzzz;
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                         input logic u, input logic [1:0] a);
    logic [31:0] s;
    logic [31:0] v;
    s = w >> (8 * a);
    if (sz == 2'b00) begin
      v = s & 32'h0000_00FF;
      if (!u && s[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      s = w >> (16 * a[1]);
      v = s & 32'h0000_FFFF;
      if (!u && s[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old_w, input logic [31:0] wd,
                                          input logic [1:0] sz, input logic [1:0] a);
    logic [31:0] mask;
    int          sh;
    sh   = (sz == 2'b00) ? 8 * a : 16 * a[1];
    mask = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    return (old_w & ~mask) | ((wd << sh) & mask);
  endfunction

  function automatic logic m_fault(input logic [1:0] sz, input logic [31:0] a);
    logic f;
    f = (sz == 2'b01) ? a[0] : (sz[1] ? (a[1:0] != 2'b00) : 1'b0);
`ifdef LSU_RANGE_CHECK_EN
    if ((a >> (AW + 2)) != 0) f = 1'b1;
`endif
    return f;
  endfunction

  // Scoreboard: every response must match the head entry, on its due cycle
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (mem_oe && (mem_we || mem_data !== mem[mem_addr])) begin
        errors++;
        $display("FAIL bus_rule: oe=%0b we=%0b data=%h required exclusive read", mem_oe, mem_we, mem_data);
      end
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: rdata=%h err=%0b with empty scoreboard", bus.rsp_rdata, bus.rsp_err);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checks++;
          if (bus.rsp_rdata !== e.rdata) begin
            errors++;
            $display("FAIL %s rdata: got %h required %h", e.name, bus.rsp_rdata, e.rdata);
          end
          checks++;
          if (bus.rsp_err !== e.err) begin
            errors++;
            $display("FAIL %s err: got %0b required %0b", e.name, bus.rsp_err, e.err);
          end
          checks++;
          if (cyc != e.due) begin
            errors++;
            $display("FAIL %s latency: rsp at cycle %0d required %0d", e.name, cyc, e.due);
          end
        end
      end
    end
  end

  // Predict outcome of a request accepted on the edge after the cycle count n
  task automatic push_exp(input logic we, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input int n,
                          input string name);
    exp_t        e;
    logic [AW-1:0] idx;
    idx    = a[AW+1:2];
    e.name = name;
    e.err  = 1'b0;
    e.rdata = 32'h0;
    if (m_fault(sz, a)) begin
      e.err = 1'b1;
      e.due = n + 1;
    end else if (we) begin
      e.due = n + (sz[1] ? 2 : 3);
      ref_mem[idx] = sz[1] ? wd : m_merge(ref_mem[idx], wd, sz, a[1:0]);
    end else begin
      e.due   = n + 2;
      e.rdata = m_load(ref_mem[idx], sz, u, a[1:0]);
    end
    exp_q.push_back(e);
  endtask

  // Drive one request, return at the negedge following its accept edge
  task automatic issue(input logic we, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input string name);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_unsigned = u; bus.req_addr = a; bus.req_wdata = wd;
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    if (!bus.req_ready) begin
      checks++; errors++;
      $display("FAIL %s accept_timeout: req_ready=%0b required 1", name, bus.req_ready);
    end
    push_exp(we, sz, u, a, wd, cyc, name);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s rsp_timeout: pending=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || mem_we !== 1'b0 ||
        mem_oe !== 1'b0 || mem_addr !== '0 || bus.rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%0b vld=%0b we=%0b oe=%0b addr=%h rdata=%h required all 0",
               bus.req_ready, bus.rsp_valid, mem_we, mem_oe, mem_addr, bus.rsp_rdata);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %0b required 1", bus.req_ready);
    end
  endtask

  task automatic test_store_word;
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, "sw_0x10");
    checks++;
    if (mem_we !== 1'b1 || mem_oe !== 1'b0 || mem_addr !== 10'd4 || mem_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL sw_wr_cycle: we=%0b oe=%0b addr=%0d data=%h required 1 0 4 deadbeef",
               mem_we, mem_oe, mem_addr, mem_data);
    end
    wait_done("sw_0x10");
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "lw_0x10");
    wait_done("lw_0x10");
  endtask

  task automatic test_subword;
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00A5, "sb_0x11");
    checks++;
    if (mem_oe !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd4) begin
      errors++;
      $display("FAIL sb_rd_cycle: oe=%0b we=%0b addr=%0d required 1 0 4", mem_oe, mem_we, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_data !== 32'hDEAD_A5EF || mem_addr !== 10'd4) begin
      errors++;
      $display("FAIL sb_wr_cycle: we=%0b data=%h addr=%0d required 1 deada5ef 4", mem_we, mem_data, mem_addr);
    end
    wait_done("sb_0x11");
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, "lb_0x11");
    issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, "lbu_0x11");
    wait_done("lbu_0x11");
    issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234, "sh_0x12");
    wait_done("sh_0x12");
    checks++;
    if (mem[4] !== 32'h1234_A5EF) begin
      errors++;
      $display("FAIL sh_mem_word: got %h required 1234a5ef", mem[4]);
    end
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, "lh_0x12");
    issue(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, "lh_0x10");
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, "lhu_0x10");
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, "lb_0x13");
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, "lw_size3");
    wait_done("lhu_0x10");
  endtask

  task automatic test_misaligned;
    issue(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, "lw_0x13");
    checks++;
    if (mem_we !== 1'b0 || mem_oe !== 1'b0) begin
      errors++;
      $display("FAIL lw_0x13_no_mem: we=%0b oe=%0b required 0 0", mem_we, mem_oe);
    end
    wait_done("lw_0x13");
    issue(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_FFFF, "sh_0x11");
    checks++;
    if (mem_we !== 1'b0 || mem_oe !== 1'b0) begin
      errors++;
      $display("FAIL sh_0x11_no_mem: we=%0b oe=%0b required 0 0", mem_we, mem_oe);
    end
    wait_done("sh_0x11");
    checks++;
    if (mem[4] !== 32'h1234_A5EF) begin
      errors++;
      $display("FAIL misaligned_mem_intact: got %h required 1234a5ef", mem[4]);
    end
  endtask

  task automatic test_reset_abort;
    issue(1'b1, 2'b00, 1'b0, 32'h20, 32'h0000_0077, "sb_0x20_abort");
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 ||
        mem_we !== 1'b0 || mem_oe !== 1'b0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_abort_outputs: ready=%0b vld=%0b err=%0b we=%0b oe=%0b addr=%h required all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_err, mem_we, mem_oe, mem_addr);
    end
    exp_q.delete();
    ref_mem[8] = 32'h0;
    @(negedge clk); rst_n = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, "lw_0x20_after_abort");
    wait_done("lw_0x20_after_abort");
  endtask

  task automatic test_back_to_back;
    int n_a;
    int n_b;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    n_a = cyc;
    push_exp(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, n_a, "b2b_lw_a");
    n_b = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        n_b = cyc;
        break;
      end
    end
    checks++;
    if (n_b != n_a + 3) begin
      errors++;
      $display("FAIL b2b_second_accept: ready at cycle %0d required %0d", n_b, n_a + 3);
    end
    bus.req_size = 2'b01; bus.req_addr = 32'h12;
    push_exp(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, n_b, "b2b_lh_b");
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_busy: got %0b required 0", bus.req_ready);
    end
    wait_done("b2b");
  endtask

  task automatic test_range;
`ifdef LSU_RANGE_CHECK_EN
    issue(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, "lw_range_fault");
    checks++;
    if (mem_oe !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL range_no_mem: oe=%0b we=%0b required 0 0", mem_oe, mem_we);
    end
`else
    issue(1'b0, 2'b10, 1'b0, 32'h0000_1010, 32'h0, "lw_alias_0x1010");
`endif
    wait_done("range");
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    test_reset();
    test_store_word();
    test_subword();
    test_misaligned();
    test_reset_abort();
    test_back_to_back();
    test_range();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: pending=%0d required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
